// File: rtl/ram_copy_engine.sv
// ram_copy_engine: word-granular memory-to-memory copy engine
// driving the DMA master port of the data-RAM arbiter.
module ram_copy_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDRESS_BITS-1:0]   src_addr,
  input  logic [ADDRESS_BITS-1:0]   dst_addr,
  input  logic [LEN_BITS-1:0]       len,
  output logic [ADDRESS_BITS-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_ready,
  input  logic                      mem_done,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      aborted,
  output logic [LEN_BITS-1:0]       words_done
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDRESS_BITS-1:0] STRIDE =
    ADDRESS_BITS'(BW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH
  } state_t;

  state_t                    state;
  state_t                    state_nx;
  logic [ADDRESS_BITS-1:0]   src;
  logic [ADDRESS_BITS-1:0]   dst;
  logic [LEN_BITS-1:0]       remaining;
  logic [TW-1:0]             timer;
  logic                      abort_pending;
  logic [DATA_WIDTH-1:0]     data;
  logic                      timeout;
  logic                      stop;

  assign timeout      = WD_ON && (timer == TLAST) && !mem_done;
  assign stop         = abort_pending || abort;
  assign busy         = (state != S_IDLE);
  assign mem_data_out = data;

  // State register; reset drops strobes in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and combinational memory-port drive.
  always_comb begin
    state_nx    = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wstrb   = '0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (len == '0) ? S_FINISH : S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_address = src;
        mem_wstrb   = '1;
        if (abort) begin
          state_nx = S_FINISH;
        end else if (mem_ready) begin
          mem_read = 1'b1;
          state_nx = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        mem_address = src;
        mem_wstrb   = '1;
        if (mem_done)
          state_nx = stop ? S_FINISH : S_WR_REQ;
        else if (timeout)
          state_nx = S_FINISH;
      end
      S_WR_REQ: begin
        mem_address = dst;
        mem_wstrb   = '1;
        if (abort) begin
          state_nx = S_FINISH;
        end else if (mem_ready) begin
          mem_write = 1'b1;
          state_nx  = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        mem_address = dst;
        mem_wstrb   = '1;
        if (mem_done) begin
          if (stop || remaining == LEN_BITS'(1))
            state_nx = S_FINISH;
          else
            state_nx = S_RD_REQ;
        end else if (timeout) begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Descriptor, progress, watchdog and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src           <= '0;
      dst           <= '0;
      remaining     <= '0;
      timer         <= '0;
      abort_pending <= 1'b0;
      data          <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      aborted       <= 1'b0;
      words_done    <= '0;
    end else begin
      done <= (state == S_FINISH);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src           <= src_addr;
            dst           <= dst_addr;
            remaining     <= len;
            error         <= 1'b0;
            aborted       <= 1'b0;
            words_done    <= '0;
            abort_pending <= 1'b0;
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (abort)          abort_pending <= 1'b1;
          else if (mem_ready) timer <= '0;
        end
        S_RD_WAIT: begin
          timer <= timer + TW'(1);
          if (abort) abort_pending <= 1'b1;
          if (mem_done)     data  <= mem_data_in;
          else if (timeout) error <= 1'b1;
        end
        S_WR_WAIT: begin
          timer <= timer + TW'(1);
          if (abort) abort_pending <= 1'b1;
          if (mem_done) begin
            words_done <= words_done + LEN_BITS'(1);
            remaining  <= remaining - LEN_BITS'(1);
            src        <= src + STRIDE;
            dst        <= dst + STRIDE;
          end else if (timeout) begin
            error <= 1'b1;
          end
        end
        S_FINISH: begin
          aborted       <= abort_pending;
          abort_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
